eth_frame_log_arbiter: RTL
==========================

Name: eth_frame_log_arbiter

Overview:
- Shares the single detection-log FIFO between the interface A and interface B frame-match paths of the frame detector.
- Grants whole log entries round-robin, prefixes each granted entry with a two-beat 64-bit timestamp header, and drives one registered stream into the log FIFO.
- Keeps per-source completed-entry counters for the AXI register file.

Parameters:
- C_DATA_WIDTH, 32, width of the log-entry beats and header beats. Must be 32: the header splits a 64-bit time into two halves.

Ports:
- clk  in  1  block clock; the log FIFO write-side clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  when low, no new grants are issued; an entry already in progress completes.
- current_time  in  64  free-running timer value.
- s_a_tdata  in  C_DATA_WIDTH  log-entry beat from interface A.
- s_a_tlast  in  1  last beat of the A entry.
- s_a_tvalid  in  1  A beat valid.
- s_a_tready  out  1  A beat accepted.
- s_b_tdata, s_b_tlast, s_b_tvalid, s_b_tready: same as the A ports, for interface B.
- m_tdata  out  C_DATA_WIDTH  output beat to the log FIFO.
- m_tlast  out  1  last beat of the output entry.
- m_tsrc  out  1  entry source (0=A, 1=B); constant for the whole entry.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  log FIFO can accept a beat.
- busy  out  1  high whenever the state is not IDLE.
- count_a  out  32  completed A entries.
- count_b  out  32  completed B entries.

Behaviour:
- Reset (async, any time, including mid-entry):
  - state=IDLE, m_tvalid=0, m_tdata=0, m_tlast=0, m_tsrc=0.
  - s_a_tready=0, s_b_tready=0, busy=0, count_a=0, count_b=0.
  - Priority pointer=A.
  - Any partial entry is discarded. No recovery or termination beat is emitted.
- Output stage:
  - One register stage, so a beat appears on m_* the cycle after it is loaded.
  - Define "adv" = !m_tvalid || m_tready.
  - Register loads only when adv is high. Otherwise it holds stable while m_tvalid=1 (AXI-Stream rule).
  - m_tvalid deasserts after a consumed beat if nothing new is loaded.
  - With m_tready held high, throughput is one beat per cycle.
- State IDLE:
  - Grant happens when enable=1 and at least one s_x_tvalid is high. A request is s_x_tvalid high on the first beat of an entry.
  - Both requesting: grant the source named by the priority pointer.
  - One requesting: grant that source regardless of the pointer.
  - On grant: latch current_time into a 64-bit register (the value in the grant cycle), latch grant source into m_tsrc, go to HDR_LO.
  - No s_x_tready is asserted in IDLE.
- State HDR_LO:
  - When adv is high, load m_tdata=ts[31:0], m_tlast=0, m_tvalid=1, then go to HDR_HI.
- State HDR_HI:
  - When adv is high, load m_tdata=ts[63:32], m_tlast=0, then go to BODY.
- State BODY:
  - s_g_tready = adv for the granted source g. The non-granted source's tready stays 0.
  - On s_g_tvalid && s_g_tready, load m_tdata=s_g_tdata and m_tlast=s_g_tlast.
  - If s_g_tvalid is low while adv is high, m_tvalid drops to 0: a bubble, no beat inserted.
  - Entry end: when the accepted beat has tlast=1:
    - increment count_g (wraps 0xFFFFFFFF -> 0);
    - set the pointer to the other source;
    - return to IDLE.
  - A new grant may issue in the cycle immediately after the tlast beat is accepted, so entries are back-to-back with no gap beyond IDLE evaluation (one cycle).
- enable:
  - Sampled only in IDLE.
  - Deasserting it in HDR_* or BODY has no effect until the entry completes.
- Single-beat entry (tlast on the first beat): emitted as 3 output beats (HDR_LO, HDR_HI, body with tlast).
- Back-pressure: m_tready=0 for any duration stalls every state with no beat loss or duplication. The timestamp is not re-sampled.
- Pointer: a fairness hint only. Completing an A entry sets the pointer to B even if B never requests.
- busy=1 in HDR_LO, HDR_HI and BODY.

Test Plan:
- Reset, then A sends a 4-beat entry 0x11,0x22,0x33,0x44 (tlast on 0x44) at current_time=0x0000_0001_0000_00AA, with m_tready=1 -> output 0x000000AA, 0x00000001, 0x11, 0x22, 0x33, 0x44 with tlast only on the last beat, m_tsrc=0, count_a=1.
- A and B both request in the same cycle after reset, each with 2-beat entries -> A's entry is emitted first, then B's immediately after, m_tsrc 0 then 1; count_a=1, count_b=1; no interleaving of beats.
- A requests continuously with 3 entries while B holds one pending entry -> order is A, B, A, A; B waits at most one A entry.
- m_tready toggles 1,0,0,1 repeating during a 5-beat B entry -> all 7 beats (2 header + 5 body) arrive in order, each exactly once, with m_tdata stable while m_tvalid=1 && !m_tready.
- enable=0 with both sources valid -> no grant and busy=0. Drop enable to 0 during A's body beat 2 of 4 -> the entry completes and then no further grant.
- Assert rst during BODY of a B entry -> within the assertion, m_tvalid=0, s_b_tready=0, busy=0, count_b=0. After release, a fresh A entry is emitted with a new timestamp header.
- Preload is not required: counter wrap is checked with 2^32 entries in formal, or by forcing count_a=0xFFFFFFFF in simulation; one more A entry -> count_a=0.

Source files
------------

// File: rtl/eth_frame_log_arbiter.sv
// Round-robin arbiter that merges the A and B frame-match log streams into one
// registered stream for the detection-log FIFO, prefixing each entry with a 64-bit timestamp.
module eth_frame_log_arbiter #(
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [63:0]             current_time,
    input  logic [C_DATA_WIDTH-1:0] s_a_tdata,
    input  logic                    s_a_tlast,
    input  logic                    s_a_tvalid,
    output logic                    s_a_tready,
    input  logic [C_DATA_WIDTH-1:0] s_b_tdata,
    input  logic                    s_b_tlast,
    input  logic                    s_b_tvalid,
    output logic                    s_b_tready,
    output logic [C_DATA_WIDTH-1:0] m_tdata,
    output logic                    m_tlast,
    output logic                    m_tsrc,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    busy,
    output logic [31:0]             count_a,
    output logic [31:0]             count_b
);

    typedef enum logic [1:0] {IDLE, HDR_LO, HDR_HI, BODY} state_t;

    state_t                  state;
    logic                    ptr;
    logic                    gnt;
    logic [63:0]             ts;
    logic                    adv;
    logic                    g_tvalid;
    logic                    g_tlast;
    logic [C_DATA_WIDTH-1:0] g_tdata;
    logic                    body_rdy;

    assign adv      = !m_tvalid || m_tready;
    assign g_tvalid = gnt ? s_b_tvalid : s_a_tvalid;
    assign g_tlast  = gnt ? s_b_tlast  : s_a_tlast;
    assign g_tdata  = gnt ? s_b_tdata  : s_a_tdata;
    assign body_rdy = (state == BODY) && adv;

    assign s_a_tready = body_rdy && !gnt;
    assign s_b_tready = body_rdy && gnt;
    assign busy       = (state != IDLE);

    // The grant is held separately from m_tsrc so that the previous entry's last
    // beat, possibly still stalled in the output register, keeps its own source tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            gnt      <= 1'b0;
            ts       <= '0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tsrc   <= 1'b0;
            m_tvalid <= 1'b0;
            count_a  <= '0;
            count_b  <= '0;
        end else begin
            if (adv) begin
                m_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable && (s_a_tvalid || s_b_tvalid)) begin
                        gnt   <= (s_a_tvalid && s_b_tvalid) ? ptr : s_b_tvalid;
                        ts    <= current_time;
                        state <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (adv) begin
                        m_tdata  <= ts[31:0];
                        m_tlast  <= 1'b0;
                        m_tsrc   <= gnt;
                        m_tvalid <= 1'b1;
                        state    <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (adv) begin
                        m_tdata  <= ts[63:32];
                        m_tlast  <= 1'b0;
                        m_tsrc   <= gnt;
                        m_tvalid <= 1'b1;
                        state    <= BODY;
                    end
                end
                BODY: begin
                    if (adv && g_tvalid) begin
                        m_tdata  <= g_tdata;
                        m_tlast  <= g_tlast;
                        m_tsrc   <= gnt;
                        m_tvalid <= 1'b1;
                        if (g_tlast) begin
                            if (gnt) count_b <= count_b + 32'd1;
                            else     count_a <= count_a + 32'd1;
                            ptr   <= !gnt;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
